// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: opcodes, phase and width constants shared by the issue stage
package alu_issue_ctrl_pkg;
  localparam int DW = 4;
  localparam logic [2:0] OP_RESET = 3'b000;
  localparam logic [2:0] OP_XNOR  = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_NAND  = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b111;
  localparam logic [1:0] PHASE_LAST = 2'd3;
  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } instr_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and result channels of the issue stage
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [2:0]    in_op;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [2:0]    alu_op;
  logic          alu_carr, alu_sign, alu_zero;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_c;
  logic          res_carr, res_sign, res_zero;
  logic [2:0]    res_op;
  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_c, alu_carr, alu_sign, alu_zero, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_carr, res_sign, res_zero, res_op
  );
  modport master (
    output in_valid, in_a, in_b, in_op, alu_c, alu_carr, alu_sign, alu_zero, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_carr, res_sign, res_zero, res_op
  );
endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_issue_fifo: synchronous instruction FIFO with full flag and occupancy count
module alu_issue_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  instr_t                   i_din,
  output instr_t                   o_dout,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  instr_t      r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
  assign o_count = r_wr - r_rd;
  assign o_full  = o_count == FULL;
  assign o_dout  = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues instructions, issues them on aligned 4-phase ALU windows and captures results
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [2:0] NOP_OP = OP_NOP
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic              busy
);
  logic [1:0]           r_phase = 2'd0;
  logic [DW-1:0]        r_alu_a, r_alu_b, r_res_c;
  logic [2:0]           r_alu_op, r_cap_op, r_res_op;
  logic                 r_in_flight, r_done, r_pend;
  logic                 r_res_valid, r_res_carr, r_res_sign, r_res_zero;
  instr_t               w_head;
  logic                 w_full, w_empty, w_push, w_last, w_first, w_free, w_issue, w_cap;
  logic [$clog2(DEPTH):0] w_count;
  alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_issue),
    .i_din({bus.in_op, bus.in_a, bus.in_b}), .o_dout(w_head), .o_full(w_full), .o_count(w_count)
  );
  assign w_empty = w_count == '0;
  assign w_push  = bus.in_valid && !w_full;
  assign w_last  = r_phase == PHASE_LAST;
  assign w_first = r_phase == 2'd0;
  assign w_free  = !r_res_valid || bus.res_ready;
  assign w_issue = w_last && !w_empty && !r_pend && w_free;
  assign w_cap   = w_free && (r_pend || (w_first && r_done));
  // Phase stays out of reset so it keeps lockstep with the ALU's own sequencer.
  always_ff @(posedge clk) r_phase <= r_phase + 2'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= NOP_OP;
      r_cap_op    <= '0;
      r_in_flight <= 1'b0;
      r_done      <= 1'b0;
      r_pend      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_c     <= '0;
      r_res_carr  <= 1'b0;
      r_res_sign  <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_op    <= '0;
    end else begin
      if (w_last) begin
        r_alu_op    <= w_issue ? w_head.op : NOP_OP;
        r_alu_a     <= w_issue ? w_head.a : r_alu_a;
        r_alu_b     <= w_issue ? w_head.b : r_alu_b;
        r_in_flight <= w_issue;
        r_done      <= r_in_flight;
        r_cap_op    <= r_in_flight ? r_alu_op : r_cap_op;
      end else if (w_first) r_done <= 1'b0;
      // A window that cannot be captured leaves the ALU on NOP, so its outputs stay valid.
      r_pend      <= w_cap ? 1'b0 : (r_pend || (w_first && r_done));
      r_res_valid <= w_cap || (r_res_valid && !bus.res_ready);
      if (w_cap) begin
        r_res_c    <= bus.alu_c;
        r_res_carr <= bus.alu_carr;
        r_res_sign <= bus.alu_sign;
        r_res_zero <= bus.alu_zero;
        r_res_op   <= r_cap_op;
      end
    end
  end
  assign bus.in_ready  = !w_full;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.res_valid = r_res_valid;
  assign bus.res_c     = r_res_c;
  assign bus.res_carr  = r_res_carr;
  assign bus.res_sign  = r_res_sign;
  assign bus.res_zero  = r_res_zero;
  assign bus.res_op    = r_res_op;
  assign busy = !w_empty || r_in_flight || r_done || r_pend;
endmodule
